// File: rtl/ev19_tcm.sv
// ev19_tcm: dual-port tightly-coupled memory with a read-only I port and a byte-writable D port.
// Supports ROM/RAM write policy, optional zero-fill after reset and I-port write forwarding.
module ev19_tcm #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned READ_LATENCY   = 1,
  parameter string       MODE           = "ROM",
  parameter int unsigned CLEAR_ON_RESET = 0,
  parameter string       INIT_FILE      = "ROM.mif"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  output logic                i_waitrequest,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_readdatavalid,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic                d_debugaccess,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_readdatavalid,
  output logic                wr_violation,
  input  logic                wr_violation_clr
);

  localparam int unsigned NUM_BYTES = DATA_W / 8;
  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam bit          IS_RAM    = (MODE == "RAM");
  localparam bit          DO_CLEAR  = IS_RAM && (CLEAR_ON_RESET != 0);

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  // Preloaded by the implementation flow; the zero-fill overwrites it when enabled.
  (* ram_init_file = INIT_FILE *)
  logic [DATA_W-1:0] mem [DEPTH];

  logic              state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              wr_violation_q, wr_violation_d;
  logic              run, clear_we, i_acc, d_rd_acc, d_wr_acc, d_blocked;
  logic [DATA_W-1:0] d_merged, i_word, d_word;
  logic              i_v1_q, d_v1_q;
  logic [DATA_W-1:0] i_d1_q, d_d1_q;

  always_comb begin
    run       = (state_q == ST_RUN);
    i_acc     = run && i_read;
    d_wr_acc  = run && d_write && (IS_RAM || d_debugaccess);
    d_blocked = run && d_write && !(IS_RAM || d_debugaccess);
    // A write always wins over a simultaneous read on the D port.
    d_rd_acc  = run && d_read && !d_write;
    clear_we  = DO_CLEAR && !run && !reset;
  end

  always_comb begin
    d_merged = mem[d_address];
    for (int unsigned k = 0; k < NUM_BYTES; k++) begin
      if (d_byteenable[k]) d_merged[8*k +: 8] = d_writedata[8*k +: 8];
    end
  end

  // The I port sees a same-cycle D write to its address as already committed.
  always_comb begin
    i_word = (d_wr_acc && (d_address == i_address)) ? d_merged : mem[i_address];
    d_word = mem[d_address];
  end

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clr_addr_q] <= '0;
    end else if (d_wr_acc) begin
      for (int unsigned k = 0; k < NUM_BYTES; k++) begin
        if (d_byteenable[k]) mem[d_address][8*k +: 8] <= d_writedata[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      if (!DO_CLEAR) begin
        state_d = ST_RUN;
      end else begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    wr_violation_d = d_blocked || (wr_violation_q && !wr_violation_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_CLEAR;
      clr_addr_q     <= '0;
      wr_violation_q <= 1'b0;
      i_v1_q         <= 1'b0;
      d_v1_q         <= 1'b0;
      i_d1_q         <= '0;
      d_d1_q         <= '0;
    end else begin
      state_q        <= state_d;
      clr_addr_q     <= clr_addr_d;
      wr_violation_q <= wr_violation_d;
      i_v1_q         <= i_acc;
      d_v1_q         <= d_rd_acc;
      if (i_acc)    i_d1_q <= i_word;
      if (d_rd_acc) d_d1_q <= d_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic              i_v2_q, d_v2_q;
    logic [DATA_W-1:0] i_d2_q, d_d2_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        i_v2_q <= 1'b0;
        d_v2_q <= 1'b0;
        i_d2_q <= '0;
        d_d2_q <= '0;
      end else begin
        i_v2_q <= i_v1_q;
        d_v2_q <= d_v1_q;
        if (i_v1_q) i_d2_q <= i_d1_q;
        if (d_v1_q) d_d2_q <= d_d1_q;
      end
    end

    assign i_readdatavalid = i_v2_q;
    assign i_readdata      = i_d2_q;
    assign d_readdatavalid = d_v2_q;
    assign d_readdata      = d_d2_q;
  end else begin : g_lat1
    assign i_readdatavalid = i_v1_q;
    assign i_readdata      = i_d1_q;
    assign d_readdatavalid = d_v1_q;
    assign d_readdata      = d_d1_q;
  end

  assign i_waitrequest = !run;
  assign d_waitrequest = !run;
  assign wr_violation  = wr_violation_q;

endmodule

// File: tb/tb_ev19_tcm.sv
// Bench for ev19_tcm: a RAM/clear/latency-1 instance and a ROM/latency-2 instance checked each
// cycle against a time-scheduled memory model, plus literal expectations from the test plan.
`timescale 1ns/1ps
module tb_ev19_tcm;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [3:0]  i_address;
    logic        i_read;
    logic [3:0]  d_address;
    logic [3:0]  d_be;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_wdata;
    logic        d_dbg;
    logic        vclr;
  } in_t;

  typedef struct packed {
    logic        iw;
    logic [31:0] ird;
    logic        irv;
    logic        dw;
    logic [31:0] drd;
    logic        drv;
    logic        viol;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  in_t  in_a, in_b;
  out_t out_a, out_b;

  logic        a_iw, a_irv, a_dw, a_drv, a_viol;
  logic [31:0] a_ird, a_drd;
  logic        b_iw, b_irv, b_dw, b_drv, b_viol;
  logic [31:0] b_ird, b_drd;

  assign out_a = {a_iw, a_ird, a_irv, a_dw, a_drd, a_drv, a_viol};
  assign out_b = {b_iw, b_ird, b_irv, b_dw, b_drd, b_drv, b_viol};

  always #5 clk = ~clk;

  ev19_tcm #(
    .DATA_W(32), .ADDR_W(4), .READ_LATENCY(1), .MODE("RAM"), .CLEAR_ON_RESET(1),
    .INIT_FILE("ROM.mif")
  ) u_ram (
    .clk(clk), .reset(rst),
    .i_address(in_a.i_address), .i_read(in_a.i_read), .i_waitrequest(a_iw),
    .i_readdata(a_ird), .i_readdatavalid(a_irv),
    .d_address(in_a.d_address), .d_byteenable(in_a.d_be), .d_read(in_a.d_read),
    .d_write(in_a.d_write), .d_writedata(in_a.d_wdata), .d_debugaccess(in_a.d_dbg),
    .d_waitrequest(a_dw), .d_readdata(a_drd), .d_readdatavalid(a_drv),
    .wr_violation(a_viol), .wr_violation_clr(in_a.vclr)
  );

  ev19_tcm #(
    .DATA_W(32), .ADDR_W(4), .READ_LATENCY(2), .MODE("ROM"), .CLEAR_ON_RESET(0),
    .INIT_FILE("ROM.mif")
  ) u_rom (
    .clk(clk), .reset(rst),
    .i_address(in_b.i_address), .i_read(in_b.i_read), .i_waitrequest(b_iw),
    .i_readdata(b_ird), .i_readdatavalid(b_irv),
    .d_address(in_b.d_address), .d_byteenable(in_b.d_be), .d_read(in_b.d_read),
    .d_write(in_b.d_write), .d_writedata(in_b.d_wdata), .d_debugaccess(in_b.d_dbg),
    .d_waitrequest(b_dw), .d_readdata(b_drd), .d_readdatavalid(b_drv),
    .wr_violation(b_viol), .wr_violation_clr(in_b.vclr)
  );

  // Model state, index 0 = RAM instance, 1 = ROM instance; port 0 = I, 1 = D.
  logic [31:0] mem_m [2][DEPTH];
  logic [3:0]  kn_m  [2][DEPTH];
  int          since [2];
  bit          viol_m [2];
  bit          sv [2][2][4];
  logic [31:0] sd [2][2][4];
  bit          sk [2][2][4];
  bit          exp_v [2][2];
  logic [31:0] exp_d [2][2];
  bit          exp_k [2][2];
  int          cyc;
  int          n_checks, n_pass;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int run_after(input int k);
    return (k == 0) ? DEPTH : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic schedule(input int k, input int p, input logic [3:0] a);
    int slot;
    slot = (cyc + lat(k) - 1) % 4;
    sv[k][p][slot] = 1'b1;
    sd[k][p][slot] = mem_m[k][a];
    sk[k][p][slot] = &kn_m[k][a];
  endtask

  task automatic model_edge(input int k, input in_t x, input logic r);
    bit blocked;
    int slot;
    if (r) begin
      since[k]  = 0;
      viol_m[k] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        for (int s = 0; s < 4; s++) sv[k][p][s] = 1'b0;
        exp_v[k][p] = 1'b0;
        exp_d[k][p] = 32'h0;
        exp_k[k][p] = 1'b1;
      end
    end else begin
      blocked = 1'b0;
      if (since[k] >= run_after(k)) begin
        if (x.d_write) begin
          if (k == 0 || x.d_dbg) begin
            for (int b = 0; b < 4; b++) begin
              if (x.d_be[b]) begin
                mem_m[k][x.d_address][8*b +: 8] = x.d_wdata[8*b +: 8];
                kn_m[k][x.d_address][b] = 1'b1;
              end
            end
          end else begin
            blocked = 1'b1;
          end
        end
        // I reads observe the write made at the same edge.
        if (x.i_read) schedule(k, 0, x.i_address);
        if (x.d_read && !x.d_write) schedule(k, 1, x.d_address);
      end
      viol_m[k] = blocked || (viol_m[k] && !x.vclr);
      if (since[k] < 1000) since[k]++;
      if (k == 0 && since[k] == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_m[k][i] = 32'h0;
          kn_m[k][i]  = 4'hF;
        end
      end
      slot = cyc % 4;
      for (int p = 0; p < 2; p++) begin
        exp_v[k][p] = sv[k][p][slot];
        if (sv[k][p][slot]) begin
          exp_d[k][p] = sd[k][p][slot];
          exp_k[k][p] = sk[k][p][slot];
        end
        sv[k][p][slot] = 1'b0;
      end
    end
  endtask

  task automatic compare(input int k, input out_t o);
    string t;
    bit    run;
    t   = (k == 0) ? "ram" : "rom";
    run = since[k] >= run_after(k);
    chk($sformatf("%s.i_waitrequest", t), o.iw, !run);
    chk($sformatf("%s.d_waitrequest", t), o.dw, !run);
    chk($sformatf("%s.i_readdatavalid", t), o.irv, exp_v[k][0]);
    chk($sformatf("%s.d_readdatavalid", t), o.drv, exp_v[k][1]);
    if (exp_k[k][0]) chk($sformatf("%s.i_readdata", t), o.ird, exp_d[k][0]);
    if (exp_k[k][1]) chk($sformatf("%s.d_readdata", t), o.drd, exp_d[k][1]);
    chk($sformatf("%s.wr_violation", t), o.viol, viol_m[k]);
  endtask

  task automatic step();
    in_t  xa, xb;
    logic r;
    @(posedge clk);
    cyc++;
    xa = in_a;
    xb = in_b;
    r  = rst;
    #1;
    model_edge(0, xa, r);
    model_edge(1, xb, r);
    compare(0, out_a);
    compare(1, out_b);
    in_a.i_read = 1'b0; in_a.d_read = 1'b0; in_a.d_write = 1'b0; in_a.vclr = 1'b0;
    in_b.i_read = 1'b0; in_b.d_read = 1'b0; in_b.d_write = 1'b0; in_b.vclr = 1'b0;
  endtask

  function automatic in_t wr(input in_t x, input int a, input logic [31:0] d,
                             input logic [3:0] be, input logic dbg);
    in_t y;
    y = x;
    y.d_write = 1'b1;
    y.d_address = 4'(a);
    y.d_wdata = d;
    y.d_be = be;
    y.d_dbg = dbg;
    return y;
  endfunction

  function automatic in_t ird(input in_t x, input int a);
    in_t y;
    y = x;
    y.i_read = 1'b1;
    y.i_address = 4'(a);
    return y;
  endfunction

  function automatic in_t drd(input in_t x, input int a);
    in_t y;
    y = x;
    y.d_read = 1'b1;
    y.d_address = 4'(a);
    return y;
  endfunction

  initial begin
    int n;
    in_a = '0;
    in_b = '0;
    rst = 1'b1;
    cyc = 0;
    n_checks = 0;
    n_pass = 0;
    for (int k = 0; k < 2; k++) begin
      since[k] = 0;
      viol_m[k] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_m[k][i] = 32'h0;
        kn_m[k][i] = 4'h0;
      end
    end

    repeat (3) step();
    rst = 1'b0;

    // Clear: reads issued while stalled must not be accepted.
    n = 0;
    do begin
      in_a = ird(in_a, n % 16);
      step();
      n++;
    end while (a_dw && n < 40);
    chk("clear_wait_cycles", 32'(n), 32'd16);

    for (int i = 0; i < 16; i++) begin
      in_a = ird(in_a, i);
      in_a = drd(in_a, 15 - i);
      step();
      chk("clear_read_valid", a_irv, 1'b1);
    end

    // Byte-enable merge
    in_a = wr(in_a, 5, 32'hAABBCCDD, 4'hF, 1'b0); step();
    in_a = wr(in_a, 5, 32'h11223344, 4'h5, 1'b0); step();
    in_a = drd(in_a, 5); step();
    chk("be_merge", a_drd, 32'hAA22CC44);

    // Read and write together: write lands, read dropped
    in_a = wr(in_a, 6, 32'h01020304, 4'hF, 1'b0); in_a = drd(in_a, 6); step();
    chk("rdwr_no_valid", a_drv, 1'b0);
    in_a = drd(in_a, 6); step();
    chk("rdwr_write_done", a_drd, 32'h01020304);

    // Cross-port forwarding
    in_a = ird(in_a, 7); in_a = wr(in_a, 7, 32'hFFFFFFFF, 4'h3, 1'b0); step();
    chk("fwd_i_readdata", a_ird, 32'h0000FFFF);
    in_a = ird(in_a, 7); step();
    chk("fwd_committed", a_ird, 32'h0000FFFF);

    // ROM instance: debug writes seed addresses 0..3
    for (int i = 0; i < 4; i++) begin
      in_b = wr(in_b, i, 32'h100 + 32'(i), 4'hF, 1'b1);
      step();
    end

    // Latency-2 pipelining
    in_b = ird(in_b, 0); step();
    chk("lat2_not_yet", b_irv, 1'b0);
    in_b = ird(in_b, 1); step();
    chk("lat2_v0", b_irv, 1'b1); chk("lat2_d0", b_ird, 32'h100);
    in_b = ird(in_b, 2); step();
    chk("lat2_v1", b_irv, 1'b1); chk("lat2_d1", b_ird, 32'h101);
    step();
    chk("lat2_v2", b_irv, 1'b1); chk("lat2_d2", b_ird, 32'h102);
    step();
    chk("lat2_done", b_irv, 1'b0); chk("lat2_hold", b_ird, 32'h102);

    // ROM write protection
    in_b = wr(in_b, 3, 32'hDEADBEEF, 4'hF, 1'b0); step();
    chk("viol_set", b_viol, 1'b1);
    in_b = drd(in_b, 3); step(); step();
    chk("rom_unchanged", b_drd, 32'h103);
    in_b = wr(in_b, 3, 32'hCAFEF00D, 4'hF, 1'b1); step();
    chk("viol_holds", b_viol, 1'b1);
    in_b = drd(in_b, 3); step(); step();
    chk("dbg_write", b_drd, 32'hCAFEF00D);
    in_b = wr(in_b, 2, 32'h0, 4'hF, 1'b0); in_b.vclr = 1'b1; step();
    chk("viol_set_wins", b_viol, 1'b1);
    in_b.vclr = 1'b1; step();
    chk("viol_clr", b_viol, 1'b0);

    // In-flight read discarded by reset
    in_b = ird(in_b, 0); step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_discard", b_irv, 1'b0);
    chk("reset_rdata", b_ird, 32'h0);

    // Reset in the middle of the clear
    repeat (9) begin
      in_a = ird(in_a, 3);
      step();
    end
    chk("midclear_wait", a_dw, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    do begin
      in_a = ird(in_a, 3);
      step();
      n++;
    end while (a_dw && n < 40);
    chk("restart_wait_cycles", 32'(n), 32'd16);
    in_a = drd(in_a, 5); step();
    chk("recleared", a_drd, 32'h0);
    in_b = ird(in_b, 1); step(); step();
    chk("rom_kept", b_ird, 32'h101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
